aes128_round_sequencer: RTL and testbench
=========================================

AES128_ROUND_SEQUENCER -- requirements
Module: aes128_round_sequencer

Interface
REQ-001 SHALL have parameter NR, default 10: number of cipher rounds. Legal range 1..15.
REQ-002 SHALL have parameter KEY_TMO, default 3: maximum WAIT cycles without kg_key_valid before an error. Legal range 1..15.
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-low.
REQ-005 in_valid  input  1  a block request is pending.
REQ-006 in_ready  output  1  the sequencer can accept a request.
REQ-007 abort  input  1  synchronous cancel of the current block.
REQ-008 kg_en  output  1  enable to the key-expansion unit.
REQ-009 kg_round  output  4  round index to the key-expansion unit; also the current round.
REQ-010 kg_key_valid  input  1  key-expansion unit has registered the round key.
REQ-011 rd_load  output  1  state register loads (plaintext XOR key0).
REQ-012 rd_en  output  1  round datapath applies one round.
REQ-013 rd_final  output  1  current round omits MixColumns.
REQ-014 out_valid  output  1  the ciphertext is available.
REQ-015 out_ready  input  1  the consumer accepts the ciphertext.
REQ-016 err  output  1  key timeout occurred; held until the next accepted request.

Function
REQ-017 SHALL implement a Moore FSM with states IDLE, KEY, WAIT, DONE, ERR; all outputs SHALL decode from registered state, round counter and the kg_key_valid input only.
REQ-018 IDLE: in_ready=1; on in_valid, SHALL go to KEY, set round=0 and clear err.
REQ-019 KEY: kg_en=1 for exactly one cycle, kg_round=round; next state SHALL be WAIT and the timeout counter SHALL clear.
REQ-020 WAIT with kg_key_valid=1:
  - rd_load=1 if round==0; otherwise rd_en=1.
  - rd_final=1 if round==NR.
  - if round==NR, next state SHALL be DONE; otherwise round+1 and next state KEY.
REQ-021 WAIT with kg_key_valid=0: the timeout counter SHALL increment; when it reaches KEY_TMO the FSM SHALL go to ERR.
REQ-022 Latency: accept edge at T; kg_en at T+1; rd_load at T+2; each further round takes 2 cycles; out_valid first high at T+2*NR+3 (T+23 for NR=10).
REQ-023 DONE: out_valid=1, held until out_ready=1; then the FSM SHALL go to IDLE. out_ready outside DONE SHALL be ignored.
REQ-024 ERR: err=1, no datapath strobes; the FSM SHALL return to IDLE on the next cycle. err SHALL stay 1 until the next accepted request.
REQ-025 kg_round SHALL never exceed NR; the round counter SHALL not wrap.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next edge.
  - No strobe (kg_en, rd_load, rd_en, out_valid) SHALL be asserted in the abort cycle.
  - abort has priority over every other transition.
  - abort in IDLE SHALL be ignored and SHALL block acceptance in that cycle.
REQ-027 in_valid SHALL be ignored outside IDLE; there is no request queueing.
REQ-028 kg_key_valid arriving in KEY, DONE or IDLE SHALL be ignored.

Reset
REQ-029 rst=0 SHALL, at the next edge, force IDLE, round=0, timeout counter=0, err=0; this applies mid-operation too.
REQ-030 Output values during and after reset SHALL be in_ready=1 and all other outputs 0.

Structure
REQ-031 The FSM state enum, NR default and the round-constant width (4) SHALL live in shared package aes_pkg.
REQ-032 The design SHALL be one module with no sub-module; the round and timeout counters SHALL be inline.

Verification
REQ-033 Single block: in_valid pulse; kg_key_valid looped back one cycle after kg_en; out_ready=1.
  - rd_load at T+2; rd_en for rounds 1..10; rd_final only with round 10; out_valid at T+23; kg_round sequence 0..10.
REQ-034 Backpressure: out_ready held 0 for 5 cycles -> out_valid stays high 5 cycles, in_ready=0 throughout, IDLE the cycle after out_ready=1.
REQ-035 Key timeout: no kg_key_valid after round 4 kg_en -> ERR after 3 WAIT cycles, err=1, next request clears err.
REQ-036 Abort in WAIT at round 6 -> no rd_en that cycle, IDLE next cycle, new request restarts at kg_round=0.
REQ-037 Reset asserted in KEY at round 7 -> all outputs 0 and in_ready=1 after the edge; no further kg_en.
REQ-038 Delayed key: kg_key_valid 2 cycles after kg_en in every round -> no error; out_valid at T+34.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round sequencer: FSM states,
// default round/timeout settings and the round-index width.
package aes_pkg;

   // Width of the round index carried to the key-expansion unit.
   localparam int RCON_W = 4;

   // AES-128 uses ten rounds after the initial key addition.
   localparam int NR_DEFAULT = 10;

   // WAIT cycles tolerated without a round key before giving up.
   localparam int KEY_TMO_DEFAULT = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      KEY  = 3'd1,
      WAIT = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } seq_state_t;

endpackage

// File: rtl/aes128_round_sequencer_if.sv
// Handshake bundle between a request source, the round sequencer, the
// key-expansion unit, the round datapath and the ciphertext consumer.
interface aes128_round_sequencer_if;
   import aes_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic              abort;
   logic              kg_en;
   logic [RCON_W-1:0] kg_round;
   logic              kg_key_valid;
   logic              rd_load;
   logic              rd_en;
   logic              rd_final;
   logic              out_valid;
   logic              out_ready;
   logic              err;

   // Environment side: issues requests, returns keys, consumes results.
   modport master (
      output in_valid, abort, kg_key_valid, out_ready,
      input  in_ready, kg_en, kg_round, rd_load, rd_en, rd_final, out_valid, err
   );

   // Sequencer side.
   modport slave (
      input  in_valid, abort, kg_key_valid, out_ready,
      output in_ready, kg_en, kg_round, rd_load, rd_en, rd_final, out_valid, err
   );

endinterface

// File: rtl/aes128_round_sequencer.sv
// Control sequencer for an iterative AES-128 core. For every round it asks
// the key-expansion unit for the round key, waits for it, then strobes the
// round datapath. A missing key for too long raises a sticky error; abort
// and reset return the sequencer to IDLE from anywhere.
module aes128_round_sequencer
   import aes_pkg::*;
#(
   parameter int NR      = NR_DEFAULT,
   parameter int KEY_TMO = KEY_TMO_DEFAULT
)(
   input  logic                    clk,
   input  logic                    rst,
   aes128_round_sequencer_if.slave bus
);

   localparam logic [RCON_W-1:0] LAST_ROUND = RCON_W'(NR);
   localparam logic [RCON_W-1:0] TMO_LIMIT  = RCON_W'(KEY_TMO);
   localparam logic [RCON_W-1:0] ONE        = RCON_W'(1);

   seq_state_t        state;
   logic [RCON_W-1:0] round;
   logic [RCON_W-1:0] tmo_cnt;
   logic              err_q;

   // State, round counter, key timeout counter and the sticky error flag.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         round   <= '0;
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else if (bus.abort && state != IDLE) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid && !bus.abort) begin
                  state <= KEY;
                  round <= '0;
                  err_q <= 1'b0;
               end
            end
            KEY: begin
               state   <= WAIT;
               tmo_cnt <= '0;
            end
            WAIT: begin
               if (bus.kg_key_valid) begin
                  if (round == LAST_ROUND) begin
                     state <= DONE;
                  end else begin
                     round <= round + ONE;
                     state <= KEY;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + ONE;
                  if (tmo_cnt + ONE == TMO_LIMIT) begin
                     state <= ERR;
                     err_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
               end
            end
            ERR: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Output decode; strobes are suppressed while abort or reset is active.
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.kg_en     = 1'b0;
      bus.kg_round  = round;
      bus.rd_load   = 1'b0;
      bus.rd_en     = 1'b0;
      bus.rd_final  = 1'b0;
      bus.out_valid = 1'b0;
      bus.err       = err_q;
      if (!rst) begin
         bus.in_ready = 1'b1;
         bus.kg_round = '0;
         bus.err      = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.in_ready = 1'b1;
            end
            KEY: begin
               bus.kg_en = !bus.abort;
            end
            WAIT: begin
               if (bus.kg_key_valid && !bus.abort) begin
                  bus.rd_load  = (round == '0);
                  bus.rd_en    = (round != '0);
                  bus.rd_final = (round == LAST_ROUND);
               end
            end
            DONE: begin
               bus.out_valid = !bus.abort;
            end
            default: begin
               bus.in_ready = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_round_sequencer.sv
// Self-checking bench for the AES-128 round sequencer. Each block is
// described by its per-round key delays, backpressure length and optional
// abort/reset point; the expected cycle-by-cycle strobes are derived from
// those numbers as an event schedule.
module tb_aes128_round_sequencer;

   localparam int NR      = 10;
   localparam int KEY_TMO = 3;
   localparam int NEVER   = 100;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;
   logic err_flag = 1'b0;
   int   dly [0:NR];

   aes128_round_sequencer_if bus ();

   aes128_round_sequencer #(.NR(NR), .KEY_TMO(KEY_TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 clk = ~clk;

   // Hard stop in case the bench itself goes astray.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic check_vector(input string tag, input logic e_rdy, input logic e_kg, input logic e_load,
                               input logic e_en, input logic e_fin, input logic e_ov, input logic e_err);
      @(negedge clk);
      check_output({tag, " in_ready"},  32'(bus.in_ready),  32'(e_rdy));
      check_output({tag, " kg_en"},     32'(bus.kg_en),     32'(e_kg));
      check_output({tag, " rd_load"},   32'(bus.rd_load),   32'(e_load));
      check_output({tag, " rd_en"},     32'(bus.rd_en),     32'(e_en));
      check_output({tag, " rd_final"},  32'(bus.rd_final),  32'(e_fin));
      check_output({tag, " out_valid"}, 32'(bus.out_valid), 32'(e_ov));
      check_output({tag, " err"},       32'(bus.err),       32'(e_err));
   endtask

   task automatic apply_stimulus(input logic iv, input logic ab, input logic kv, input logic ordy, input logic rn);
      @(posedge clk);
      #1;
      bus.in_valid     = iv;
      bus.abort        = ab;
      bus.kg_key_valid = kv;
      bus.out_ready    = ordy;
      rst              = rn;
   endtask

   task automatic idle_cycles(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         apply_stimulus(1'b0, rbit(), rbit(), rbit(), 1'b1);
         check_vector($sformatf("%s i%0d", tag, i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err_flag);
      end
   endtask

   // One block from acceptance back to IDLE, using dly[] for key latency.
   task automatic run_block(input string name, input int bp, input int abort_round, input int reset_round);
      int   t_key [0:NR];
      int   r_last, end_c, err_c, out_c, abort_c, reset_c, ev_round, key_round;
      logic key_ev, is_key, in_done, kv, ordy;
      string tag;

      err_c = -1; out_c = -1; abort_c = -1; reset_c = -1; end_c = 0; r_last = 0;
      t_key[0] = 1;
      for (int r = 0; r <= NR; r++) begin
         if (r > 0) t_key[r] = t_key[r-1] + dly[r-1] + 1;
         r_last = r;
         if (r == reset_round) begin reset_c = t_key[r]; end_c = reset_c; break; end
         if (r == abort_round) begin abort_c = t_key[r] + 1; end_c = abort_c; break; end
         if (dly[r] > KEY_TMO) begin err_c = t_key[r] + KEY_TMO + 1; end_c = err_c; break; end
         if (r == NR) begin out_c = t_key[r] + dly[r] + 1; end_c = out_c + bp; end
      end

      apply_stimulus(1'b1, 1'b0, rbit(), rbit(), 1'b1);
      check_vector({name, " accept"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err_flag);
      err_flag = 1'b0;

      for (int c = 1; c <= end_c; c++) begin
         is_key = 1'b0; key_round = 0; key_ev = 1'b0; ev_round = 0;
         for (int r = 0; r <= r_last; r++) begin
            if (c == t_key[r]) begin is_key = 1'b1; key_round = r; end
            if (c == t_key[r] + dly[r] && (r < r_last || out_c >= 0)) begin
               key_ev = 1'b1; ev_round = r;
            end
         end
         in_done = (out_c >= 0 && c >= out_c);
         kv   = key_ev || (c == abort_c) || ((is_key || in_done) && rbit());
         ordy = in_done ? (c == end_c) : rbit();
         apply_stimulus(rbit(), c == abort_c, kv, ordy, c != reset_c);
         tag = $sformatf("%s c%0d", name, c);
         if (c == reset_c) begin
            err_flag = 1'b0;
            check_vector(tag, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            check_output({tag, " kg_round"}, 32'(bus.kg_round), 32'd0);
         end else begin
            if (c == err_c) err_flag = 1'b1;
            check_vector(tag, 1'b0, is_key, key_ev && ev_round == 0, key_ev && ev_round > 0,
                         key_ev && ev_round == NR, in_done, err_flag);
            if (is_key) check_output({tag, " kg_round"}, 32'(bus.kg_round), 32'(key_round));
         end
      end

      apply_stimulus(1'b0, 1'b0, rbit(), rbit(), 1'b1);
      check_vector({name, " end"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err_flag);
   endtask

   task automatic set_delays(input int d);
      for (int r = 0; r <= NR; r++) dly[r] = d;
   endtask

   initial begin
      int ab_round;
      rst              = 1'b0;
      bus.in_valid     = 1'b0;
      bus.abort        = 1'b0;
      bus.kg_key_valid = 1'b0;
      bus.out_ready    = 1'b0;

      $display("[TB] reset behaviour");
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(rbit(), rbit(), rbit(), rbit(), 1'b0);
         check_vector($sformatf("reset r%0d", i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         check_output($sformatf("reset r%0d kg_round", i), 32'(bus.kg_round), 32'd0);
      end
      idle_cycles("post_reset_idle", 2);

      $display("[TB] single block");
      set_delays(1);
      run_block("single", 0, -1, -1);

      $display("[TB] backpressure");
      run_block("backpressure", 5, -1, -1);

      $display("[TB] key timeout and error clear");
      set_delays(1);
      dly[4] = NEVER;
      run_block("timeout", 0, -1, -1);
      idle_cycles("err_hold", 2);
      set_delays(1);
      run_block("err_clear", 0, -1, -1);

      $display("[TB] abort in IDLE blocks acceptance");
      apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check_vector("idle_abort", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, err_flag);
      idle_cycles("idle_abort_after", 1);

      $display("[TB] abort in WAIT and restart");
      run_block("abort", 0, 6, -1);
      run_block("restart", 0, -1, -1);

      $display("[TB] reset mid-block");
      run_block("midreset", 0, -1, 7);
      idle_cycles("midreset_idle", 4);

      $display("[TB] delayed keys");
      set_delays(2);
      run_block("delayed", 0, -1, -1);

      $display("[TB] randomized blocks");
      for (int b = 0; b < 10; b++) begin
         for (int r = 0; r <= NR; r++) dly[r] = int'($urandom_range(1, KEY_TMO));
         if ($urandom_range(0, 3) == 0) dly[$urandom_range(0, NR)] = KEY_TMO + 1;
         ab_round = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR)) : -1;
         run_block($sformatf("rand%0d", b), int'($urandom_range(0, 3)), ab_round, -1);
         idle_cycles($sformatf("rand%0d_gap", b), int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
